serial_frame_rx: RTL and testbench

Standalone receiving end of the two-wire sen/sd serial link: deserialises address+data frames sent by a link transmitter and writes each good frame into a register bank through an RB-style write port. Detects short and long frames, counts them, and raises a sticky done flag once the frame for LAST_ADDR has been committed. Sits between the pad-side sen/sd nets and the local register bank, in place of the receive half of a bidirectional link controller.

---
 rtl/link_pkg.sv | 16 +
 rtl/sat_counter.sv | 30 +++
 rtl/serial_frame_rx.sv | 134 +++++++++++++
 tb/tb_serial_frame_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared constants and state encoding for the two-wire sen/sd serial link.
// The transmit side imports this package so both ends agree on frame geometry.
package link_pkg;

  localparam int unsigned LINK_ADDR_W    = 5;
  localparam int unsigned LINK_DATA_W    = 8;
  localparam int unsigned LINK_LAST_ADDR = 17;
  localparam int unsigned LINK_ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that increments on inc_i and sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Receive side of the sen/sd link: deserialises address+data frames, commits good
// frames to the register bank write port, and flags/counts short and long frames.
module serial_frame_rx
  import link_pkg::*;
#(
  parameter int unsigned ADDR_W    = LINK_ADDR_W,
  parameter int unsigned DATA_W    = LINK_DATA_W,
  parameter int unsigned LAST_ADDR = LINK_LAST_ADDR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sen,
  input  logic                      sd,
  output logic                      rb_rw,
  output logic [ADDR_W-1:0]         rb_a,
  output logic [DATA_W-1:0]         rb_d,
  output logic                      done,
  output logic                      frame_err,
  output logic [LINK_ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned FRAME_LEN = ADDR_W + DATA_W;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic                   rb_rw_q, rb_rw_d;
  logic [ADDR_W-1:0]      rb_a_q, rb_a_d;
  logic [DATA_W-1:0]      rb_d_q, rb_d_d;
  logic                   done_q, done_d;
  logic                   frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rb_rw_q     <= 1'b1;
      rb_a_q      <= '0;
      rb_d_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rb_rw_q     <= rb_rw_d;
      rb_a_q      <= rb_a_d;
      rb_d_q      <= rb_d_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame FSM: the edge sampling sen high decides commit vs. short-frame error.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rb_rw_d     = 1'b1;
    rb_a_d      = rb_a_q;
    rb_d_d      = rb_d_q;
    done_d      = done_q;
    frame_err_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!sen) begin
            shift_d = {shift_q[FRAME_LEN-2:0], sd};
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (!sen) begin
            if (cnt_q == CNT_W'(FRAME_LEN)) begin
              frame_err_d = 1'b1;
              cnt_d       = '0;
              state_d     = DRAIN;
            end else begin
              shift_d = {shift_q[FRAME_LEN-2:0], sd};
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
            if (cnt_q == CNT_W'(FRAME_LEN)) begin
              rb_rw_d = 1'b0;
              rb_a_d  = shift_q[FRAME_LEN-1:DATA_W];
              rb_d_d  = shift_q[DATA_W-1:0];
              if (shift_q[FRAME_LEN-1:DATA_W] == ADDR_W'(LAST_ADDR)) begin
                done_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (sen) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Error counter advances on the same edge that raises frame_err.
  sat_counter #(
    .W(LINK_ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(frame_err_d),
    .cnt_o(err_cnt)
  );

  assign rb_rw     = rb_rw_q;
  assign rb_a      = rb_a_q;
  assign rb_d      = rb_d_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: a frame-level model queues expected
// writes and error counts; a monitor checks each strobe or error pulse.
module tb_serial_frame_rx;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 8;
  localparam int unsigned FL   = AW + DW;
  localparam int unsigned LAST = 17;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          dn;
  } wr_t;

  logic          clk, rst, en, sen, sd;
  logic          rb_rw, done, frame_err;
  logic [AW-1:0] rb_a;
  logic [DW-1:0] rb_d;
  logic [7:0]    err_cnt;

  int  n_vec = 0;
  int  n_bad = 0;
  wr_t wq[$];
  int  eq[$];
  int  exp_err = 0;
  logic done_exp = 1'b0;
  logic [AW-1:0] last_a = '0;
  logic [DW-1:0] last_d = '0;

  serial_frame_rx dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sen      (sen),
    .sd       (sd),
    .rb_rw    (rb_rw),
    .rb_a     (rb_a),
    .rb_d     (rb_d),
    .done     (done),
    .frame_err(frame_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sen = 1'b1;
      sd  = 1'($urandom);
    end
  endtask

  // Frame-level model: exactly FL bits is a write, anything else one error.
  task automatic send_frame(input logic [63:0] bits, input int len, input int gap);
    wr_t w;
    if (len == FL) begin
      w.a = bits[FL-1:DW];
      w.d = bits[DW-1:0];
      if (32'(w.a) == LAST) done_exp = 1'b1;
      w.dn = done_exp;
      wq.push_back(w);
    end else begin
      if (exp_err < 255) exp_err++;
      eq.push_back(exp_err);
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      sen = 1'b0;
      sd  = bits[len-1-i];
    end
    idle(gap);
  endtask

  task automatic send_good(input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
    send_frame(64'({a, d}), FL, gap);
  endtask

  // Monitor: every strobe or error pulse must match the head of its queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_a = '0;
        last_d = '0;
      end else begin
        if (rb_rw == 1'b0) begin
          check("no_err_with_wr", 32'(frame_err), 32'd0);
          if (wq.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
          end else begin
            e = wq.pop_front();
            check("wr_addr", 32'(rb_a), 32'(e.a));
            check("wr_data", 32'(rb_d), 32'(e.d));
            check("wr_done", 32'(done), 32'(e.dn));
          end
          last_a = rb_a;
          last_d = rb_d;
        end else begin
          check("hold_addr", 32'(rb_a), 32'(last_a));
          check("hold_data", 32'(rb_d), 32'(last_d));
        end
        if (frame_err) begin
          if (eq.size() == 0) begin
            check("unexpected_err", 32'd1, 32'd0);
          end else begin
            check("err_cnt", 32'(err_cnt), 32'(eq.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, gap, k;
    rst = 1'b0; en = 1'b0; sen = 1'b1; sd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rb_rw", 32'(rb_rw), 32'd1);
    check("rst_rb_a", 32'(rb_a), 32'd0);
    check("rst_rb_d", 32'(rb_d), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_errcnt", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    en  = 1'b1;
    idle(2);

    send_good(5'd3, 8'hA5, 3);
    check("done_before_last", 32'(done), 32'd0);
    send_good(5'd17, 8'h3C, 3);
    send_good(5'd2, 8'h5E, 3);
    check("done_sticky", 32'(done), 32'd1);

    send_frame(64'h2A5, 10, 3);
    send_frame(64'hF0F0F, 20, 3);
    send_good(5'd9, 8'hC3, 3);

    send_good(5'd4, 8'h11, 1);
    send_good(5'd6, 8'h22, 3);

    // Abort after 7 bits by dropping en, then re-enable with sen high.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); sen = 1'b0; sd = 1'($urandom);
    end
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    sen = 1'b1;
    @(negedge clk); en = 1'b1;
    idle(3);
    check("en_abort_errcnt", 32'(err_cnt), 32'(exp_err));
    send_good(5'd11, 8'h96, 3);

    // en falls on the commit edge: that write must be dropped.
    for (int i = 0; i < FL; i++) begin
      @(negedge clk); sen = 1'b0; sd = 1'($urandom);
    end
    @(negedge clk); sen = 1'b1; en = 1'b0;
    @(negedge clk); en = 1'b1;
    idle(3);
    send_good(5'd21, 8'h0F, 2);

    for (int n = 0; n < 60; n++) begin
      k   = int'($urandom_range(0, 9));
      gap = int'($urandom_range(1, 3));
      if (k < 2) begin
        len = int'($urandom_range(1, FL - 1));
        send_frame({$urandom, $urandom}, len, gap);
      end else if (k == 2) begin
        len = int'($urandom_range(FL + 1, 24));
        send_frame({$urandom, $urandom}, len, gap);
      end else begin
        send_good(AW'($urandom), DW'($urandom), gap);
      end
    end

    for (int n = 0; n < 260; n++) begin
      send_frame(64'($urandom), int'($urandom_range(1, 4)), 1);
    end
    send_good(5'd17, 8'h3C, 2);

    for (int t = 0; t < 40 && (wq.size() != 0 || eq.size() != 0); t++) begin
      @(negedge clk);
    end
    check("queues_drained", 32'(wq.size() + eq.size()), 32'd0);
    check("errcnt_saturated", 32'(err_cnt), 32'd255);
    check("errcnt_model", 32'(err_cnt), 32'(exp_err));
    check("done_final", 32'(done), 32'(done_exp));
    send_frame(64'h1, 2, 3);
    check("errcnt_holds", 32'(err_cnt), 32'd255);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); sen = 1'b0; sd = 1'($urandom);
    end
    #2 rst = 1'b0;
    #1;
    check("arst_rb_rw", 32'(rb_rw), 32'd1);
    check("arst_rb_a", 32'(rb_a), 32'd0);
    check("arst_rb_d", 32'(rb_d), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_ferr", 32'(frame_err), 32'd0);
    check("arst_errcnt", 32'(err_cnt), 32'd0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
